// File: rtl/prog_clk_divider.sv
// prog_clk_divider: programmable clock divider with square, pulse and duty modes.
// Settings load into a pending slot and take effect only at a period boundary.
//
// Ports:
//   clk      - single clock, all logic on its rising edge
//   rst      - asynchronous active-high reset
//   en       - count enable
//   div_ld   - one-cycle strobe, captures div_val/mode/duty_val as pending
//   div_val  - requested divisor (0 and 1 are treated as 2)
//   mode     - 0/3 square, 1 single-cycle pulse, 2 programmable duty
//   duty_val - high-cycle count used in mode 2
//   clkout   - registered divided clock
//   tick     - registered strobe, high on the last cycle of each period
//   pend     - a loaded setting is waiting for the next boundary
//   cur_div  - active effective divisor
module prog_clk_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_ld,
    input  logic [WIDTH-1:0] div_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] duty_val,
    output logic             clkout,
    output logic             tick,
    output logic             pend,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
    localparam logic [WIDTH-1:0] DEF_D =
        (DEFAULT_DIV < 2) ? TWO : WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] act_d;
    logic [1:0]       act_mode;
    logic [WIDTH-1:0] act_duty;
    logic [WIDTH-1:0] pnd_d;
    logic [1:0]       pnd_mode;
    logic [WIDTH-1:0] pnd_duty;
    logic [WIDTH-1:0] cnt;

    logic [WIDTH-1:0] ld_d;
    logic             at_end;
    logic             apply;
    logic [WIDTH-1:0] nxt_d;
    logic [1:0]       nxt_mode;
    logic [WIDTH-1:0] nxt_duty;
    logic [WIDTH-1:0] nxt_h;
    logic [WIDTH-1:0] cnt_next;

    // High-cycle threshold; always lands in 1..d-1 so every
    // period has at least one high and one low cycle.
    function automatic logic [WIDTH-1:0] hi_thresh(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic [WIDTH-1:0] du
    );
        logic [WIDTH-1:0] h;
        h = d >> 1;
        case (m)
            2'd1: h = ONE;
            2'd2: begin
                if (du == '0)
                    h = ONE;
                else if (du > d - ONE)
                    h = d - ONE;
                else
                    h = du;
            end
            default: h = d >> 1;
        endcase
        return h;
    endfunction

    assign ld_d    = (div_val < TWO) ? TWO : div_val;
    assign at_end  = (cnt == act_d - ONE);

    // Swap at the boundary while running; when stopped there is no
    // boundary to wait for, so swap on the next edge.
    assign apply   = pend && (en ? at_end : 1'b1);

    assign nxt_d    = apply ? pnd_d    : act_d;
    assign nxt_mode = apply ? pnd_mode : act_mode;
    assign nxt_duty = apply ? pnd_duty : act_duty;
    assign nxt_h    = hi_thresh(nxt_d, nxt_mode, nxt_duty);
    assign cnt_next = at_end ? '0 : cnt + ONE;

    assign cur_div = act_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            clkout   <= 1'b0;
            tick     <= 1'b0;
            pend     <= 1'b0;
            act_d    <= DEF_D;
            act_mode <= 2'd0;
            act_duty <= ONE;
            pnd_d    <= DEF_D;
            pnd_mode <= 2'd0;
            pnd_duty <= ONE;
        end else begin
            if (en) begin
                cnt    <= cnt_next;
                clkout <= (cnt_next < nxt_h);
                tick   <= (cnt_next == nxt_d - ONE);
            end else begin
                tick <= 1'b0;
                if (apply)
                    cnt <= '0;
            end

            if (apply) begin
                act_d    <= pnd_d;
                act_mode <= pnd_mode;
                act_duty <= pnd_duty;
            end

            // A load on the swap edge stays pending for the next boundary.
            if (div_ld) begin
                pnd_d    <= ld_d;
                pnd_mode <= mode;
                pnd_duty <= duty_val;
                pend     <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed bench for prog_clk_divider.
// Expected values are queued when stimulus is driven, popped at each check.
module tb_prog_clk_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       div_ld;
    logic [7:0] div_val;
    logic [1:0] mode;
    logic [7:0] duty_val;
    logic       clkout;
    logic       tick;
    logic       pend;
    logic [7:0] cur_div;

    typedef struct {
        string tag;
        int    v;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    prog_clk_divider #(.WIDTH(8), .DEFAULT_DIV(8)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .div_ld(div_ld),
        .div_val(div_val),
        .mode(mode),
        .duty_val(duty_val),
        .clkout(clkout),
        .tick(tick),
        .pend(pend),
        .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input string tag, input int v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty observed=%0d expected=queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === 32'(e.v)) passed++;
            else $error("FAIL %s observed=%0d expected=%0d",
                        e.tag, obs, e.v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_count(inout int h, inout int l);
        step();
        if (clkout === 1'b1) h++;
        else l++;
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (tick !== 1'b1) begin
            expect_v({tag, "_tick_timeout"}, 1);
            chk(32'(tick));
        end
    endtask

    task automatic count_until_tick(inout int h, inout int l);
        int n;
        n = 0;
        do begin
            step_count(h, l);
            n++;
        end while (tick !== 1'b1 && n < 64);
    endtask

    task automatic measure_from_tick(input string tag,
                                     input int eh, input int el);
        int h;
        int l;
        h = 0;
        l = 0;
        expect_v({tag, "_hi"}, eh);
        expect_v({tag, "_lo"}, el);
        count_until_tick(h, l);
        chk(32'(h));
        chk(32'(l));
    endtask

    task automatic measure(input string tag, input int eh, input int el);
        wait_tick(tag);
        measure_from_tick(tag, eh, el);
    endtask

    // Never strobe on a boundary edge: step off a tick cycle first.
    task automatic load(input int d, input int m, input int du);
        if (tick === 1'b1) step();
        div_ld   = 1'b1;
        div_val  = 8'(d);
        mode     = 2'(m);
        duty_val = 8'(du);
        step();
        div_ld   = 1'b0;
        expect_v("pend_after_load", 1);
        chk(32'(pend));
    endtask

    initial begin
        int h;
        int l;
        int bad;

        rst      = 1'b1;
        en       = 1'b0;
        div_ld   = 1'b0;
        div_val  = '0;
        mode     = '0;
        duty_val = '0;

        #23;
        expect_v("rst_clkout", 0);
        expect_v("rst_tick", 0);
        expect_v("rst_pend", 0);
        expect_v("rst_cur_div", 8);
        chk(32'(clkout));
        chk(32'(tick));
        chk(32'(pend));
        chk(32'(cur_div));

        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        expect_v("first_edge_clkout", 1);
        expect_v("first_edge_tick", 0);
        step();
        chk(32'(clkout));
        chk(32'(tick));

        measure("d8_default", 4, 4);
        expect_v("d8_cur_div", 8);
        chk(32'(cur_div));

        load(5, 0, 0);
        wait_tick("d5");
        expect_v("pend_until_boundary", 1);
        chk(32'(pend));
        measure_from_tick("d5_square", 2, 3);
        expect_v("d5_pend_clear", 0);
        expect_v("d5_cur_div", 5);
        chk(32'(pend));
        chk(32'(cur_div));

        load(4, 1, 0);
        measure("d4_pulse", 1, 3);
        load(10, 2, 3);
        measure("d10_duty3", 3, 7);
        load(10, 2, 0);
        measure("d10_duty0", 1, 9);
        load(10, 2, 15);
        measure("d10_duty15", 9, 1);

        load(8, 0, 0);
        measure("d8_again", 4, 4);
        h = 0;
        l = 0;
        expect_v("midload_cur_hi", 4);
        expect_v("midload_cur_lo", 4);
        for (int i = 0; i < 4; i++) step_count(h, l);
        div_ld   = 1'b1;
        div_val  = 8'd4;
        mode     = 2'd0;
        duty_val = 8'd0;
        step_count(h, l);
        div_ld   = 1'b0;
        count_until_tick(h, l);
        chk(32'(h));
        chk(32'(l));
        measure_from_tick("midload_next", 2, 2);

        load(0, 0, 0);
        measure("d0_period", 1, 1);
        expect_v("d0_cur_div", 2);
        chk(32'(cur_div));
        load(1, 0, 0);
        measure("d1_period", 1, 1);
        expect_v("d1_cur_div", 2);
        chk(32'(cur_div));

        load(10, 0, 0);
        measure("d10_square", 5, 5);
        h = 0;
        l = 0;
        for (int i = 0; i < 3; i++) step_count(h, l);
        en  = 1'b0;
        bad = 0;
        expect_v("en_hold_bad", 0);
        for (int i = 0; i < 5; i++) begin
            step();
            if (clkout !== 1'b1 || tick !== 1'b0) bad++;
        end
        chk(32'(bad));
        en = 1'b1;
        expect_v("en_resume_hi", 5);
        expect_v("en_resume_lo", 5);
        count_until_tick(h, l);
        chk(32'(h));
        chk(32'(l));

        en = 1'b0;
        load(4, 0, 0);
        expect_v("stopped_apply_pend", 0);
        expect_v("stopped_apply_cur_div", 4);
        expect_v("stopped_apply_clkout", 0);
        step();
        chk(32'(pend));
        chk(32'(cur_div));
        chk(32'(clkout));
        en = 1'b1;
        measure("stopped_apply_run", 2, 2);

        load(5, 0, 0);
        expect_v("pre_rst_clkout", 1);
        chk(32'(clkout));
        #2;
        rst = 1'b1;
        #1;
        expect_v("async_rst_clkout", 0);
        expect_v("async_rst_pend", 0);
        expect_v("async_rst_cur_div", 8);
        expect_v("async_rst_tick", 0);
        chk(32'(clkout));
        chk(32'(pend));
        chk(32'(cur_div));
        chk(32'(tick));
        #1;
        rst = 1'b0;
        measure("post_rst", 4, 4);
        expect_v("post_rst_cur_div", 8);
        chk(32'(cur_div));

        if (sb.size() != 0) begin
            total++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
